extrema_scan_ctrl: RTL
======================

EXTREMA_SCAN_CTRL -- requirements
Module: extrema_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 252, columns per DoG row (column index 0..WIDTH-1).
REQ-002 SHALL have parameter HEIGHT, default 200, rows per DoG frame.
REQ-003 SHALL have parameter PARK, default 252, the idle column code driven to the 3x3 window matrix (any value >= WIDTH).
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle frame start request.
REQ-007 SHALL have port in_valid  input  1  DoG sample valid.
REQ-008 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-009 SHALL have port in_dog  input  17  signed DoG sample, raster order.
REQ-010 SHALL have port mtx_x  output  8  column index to the window matrix.
REQ-011 SHALL have port mtx_y  output  8  row index to the window matrix.
REQ-012 SHALL have port mtx_dir  output  1  row direction, mtx_y[0].
REQ-013 SHALL have port mtx_dog  output  17  sample to the window matrix.
REQ-014 SHALL have port win_valid  output  1  matrix 3x3 outputs hold a valid window this cycle.
REQ-015 SHALL have port win_x  output  8  window centre column.
REQ-016 SHALL have port win_y  output  8  window centre row.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement states IDLE, SCAN, FLUSH, DONE.
- IDLE -> SCAN on start=1; start in any other state ignored.
- SCAN -> FLUSH after the beat at (x=WIDTH-1, y=HEIGHT-1) when HEIGHT mod 4 != 0; otherwise SCAN -> DONE.
- FLUSH -> DONE after the last column of the last pad row.
- DONE -> IDLE unconditionally after one cycle.
REQ-020 SHALL assert in_ready only in SCAN; a beat is accepted when in_valid and in_ready are both 1.
REQ-021 SHALL keep column counter x (0..WIDTH-1) and row counter y (0..HEIGHT+pad-1); x increments per accepted beat (SCAN) or per cycle (FLUSH), wraps WIDTH-1 -> 0 with y+1.
REQ-022 SHALL register mtx_x=x, mtx_y=y, mtx_dir=y[0], mtx_dog=in_dog one cycle after each accepted beat (latency 1).
REQ-023 SHALL drive mtx_x=PARK, mtx_dog=0 on every cycle without an accepted beat or flush beat, with mtx_y and mtx_dir held, so a stall never re-presents column WIDTH-1 to the matrix.
REQ-024 SHALL in FLUSH issue one beat per cycle with mtx_dog=0 for (4 - HEIGHT mod 4) pad rows, returning the matrix row phase to 0.
REQ-025 SHALL assert win_valid two cycles after an accepted SCAN beat with y>=3 and x<=WIDTH-3, with win_x=x+1 and win_y=y-2 from that beat; win_valid SHALL be 0 for FLUSH beats.
REQ-026 SHALL pulse frame_done for exactly the DONE cycle; busy=0 only in IDLE.
REQ-027 SHALL use 8-bit unsigned counters; no counter SHALL exceed WIDTH-1 (x) or HEIGHT+3 (y).
REQ-028 SHALL on in_valid deasserting mid-row hold x and y and resume at the same column without loss or duplication.
REQ-029 SHALL on start coinciding with DONE ignore start; a new frame needs start in IDLE.

Reset
REQ-030 SHALL on rst=0, asynchronously: state=IDLE, x=y=0, mtx_x=PARK, mtx_y=0, mtx_dir=0, mtx_dog=0, in_ready=0, win_valid=0, win_x=win_y=0, busy=0, frame_done=0.
REQ-031 SHALL on reset mid-frame discard the partial frame; next frame restarts at (0,0) after start.

Verification
REQ-032 SHALL verify continuous frame, HEIGHT=8: start, in_valid=1 -> 2016 accepted beats, no FLUSH, frame_done one cycle later, first win_valid at beat (0,3)+2 cycles with win_x=1, win_y=1.
REQ-033 SHALL verify padding, HEIGHT=6: -> 2 pad rows (504 zero beats) in FLUSH, win_valid=0 throughout FLUSH, mtx_y ends at 7.
REQ-034 SHALL verify stall at x=251: in_valid=0 for 5 cycles before last column -> mtx_x=252 for 5 cycles, then x=251 presented once, mtx_y increments once.
REQ-035 SHALL verify window column bound: beats x=249,250,251 on row 3 -> win_valid 1,0,0 two cycles later.
REQ-036 SHALL verify async reset mid-row (x=100, y=4): rst=0 without clock edge -> all outputs at REQ-030 values immediately; start resumes at (0,0).
REQ-037 SHALL verify start during SCAN and DONE -> ignored, no restart, counters unaffected.

Source files
------------

// File: rtl/extrema_scan_ctrl.sv
// extrema_scan_ctrl: raster scan controller feeding a 3x3 DoG window matrix, padding rows to a multiple of 4
module extrema_scan_ctrl #(
  parameter int WIDTH  = 252,
  parameter int HEIGHT = 200,
  parameter int PARK   = 252
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_dog,
  output logic [7:0]  mtx_x,
  output logic [7:0]  mtx_y,
  output logic        mtx_dir,
  output logic [16:0] mtx_dog,
  output logic        win_valid,
  output logic [7:0]  win_x,
  output logic [7:0]  win_y,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  localparam int PAD = (HEIGHT % 4 == 0) ? 0 : 4 - HEIGHT % 4;
  localparam logic HAS_PAD = PAD != 0;
  localparam logic [7:0] XL = 8'(WIDTH - 1);
  localparam logic [7:0] XW = 8'(WIDTH - 3);
  localparam logic [7:0] YL = 8'(HEIGHT - 1);
  localparam logic [7:0] YF = 8'(HEIGHT + PAD - 1);
  localparam logic [7:0] XP = 8'(PARK);
  logic [1:0]  state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d, mx_q, mx_d, my_q, my_d;
  logic [7:0]  wx1_q, wx1_d, wy1_q, wy1_d, wx_q, wx_d, wy_q, wy_d;
  logic [16:0] md_q, md_d;
  logic        wv1_q, wv1_d, wv_q, wv_d;
  logic        acc, beat, eol, last;
  always_comb begin
    acc     = state_q == SCAN && in_valid;
    beat    = acc || state_q == FLUSH;
    eol     = x_q == XL;
    last    = eol && (acc ? y_q == YL : y_q == YF);
    x_d     = beat ? (eol ? 8'd0 : x_q + 8'd1) : x_q;
    y_d     = !(beat && eol) ? y_q : (last && !(acc && HAS_PAD)) ? 8'd0 : y_q + 8'd1;
    state_d = state_q == IDLE ? (start ? SCAN : IDLE) :
              state_q == DONE ? IDLE :
              (beat && last) ? ((acc && HAS_PAD) ? FLUSH : DONE) : state_q;
    mx_d    = beat ? x_q : XP;
    my_d    = beat ? y_q : my_q;
    md_d    = acc ? in_dog : 17'd0;
    wv1_d   = acc && y_q >= 8'd3 && x_q <= XW;
    wx1_d   = x_q + 8'd1;
    wy1_d   = y_q - 8'd2;
    wv_d    = wv1_q;
    wx_d    = wv1_q ? wx1_q : wx_q;
    wy_d    = wv1_q ? wy1_q : wy_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      mx_q    <= XP;
      my_q    <= 8'd0;
      md_q    <= 17'd0;
      wv1_q   <= 1'b0;
      wx1_q   <= 8'd0;
      wy1_q   <= 8'd0;
      wv_q    <= 1'b0;
      wx_q    <= 8'd0;
      wy_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      md_q    <= md_d;
      wv1_q   <= wv1_d;
      wx1_q   <= wx1_d;
      wy1_q   <= wy1_d;
      wv_q    <= wv_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end
  assign in_ready   = state_q == SCAN;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign mtx_x      = mx_q;
  assign mtx_y      = my_q;
  assign mtx_dir    = my_q[0];
  assign mtx_dog    = md_q;
  assign win_valid  = wv_q;
  assign win_x      = wx_q;
  assign win_y      = wy_q;
endmodule
